// File: rtl/rename_alloc_unit.sv
// Rename/allocation stage: hands out RRF tags from a circular free list, tracks
// the architectural-to-RRF map, and returns tags to the list on retire.
module rename_alloc_unit #(
    parameter int ARCH_REGS = 32,
    parameter int RRF_DEPTH = 16,
    parameter int TAG_W     = 4,
    parameter int RD_W      = $clog2(ARCH_REGS)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             ALLOC_REQ,
    input  logic [RD_W-1:0]  ALLOC_RD,
    input  logic [RD_W-1:0]  SRC1_RS,
    input  logic [RD_W-1:0]  SRC2_RS,
    output logic             ALLOC_GNT,
    output logic [TAG_W-1:0] ALLOC_TAG,
    output logic             ALLOC_TAG_VALID,
    output logic             STALL,
    output logic             SRC1_RENAMED,
    output logic [TAG_W-1:0] SRC1_TAG,
    output logic             SRC2_RENAMED,
    output logic [TAG_W-1:0] SRC2_TAG,
    input  logic             RETIRE_EN,
    input  logic [TAG_W-1:0] RETIRE_TAG,
    input  logic [RD_W-1:0]  RETIRE_RD,
    output logic [TAG_W:0]   FREE_COUNT,
    output logic             ERR
);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } map_entry_t;

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W + 1)'(RRF_DEPTH);

    logic [TAG_W-1:0] free_list [RRF_DEPTH];
    map_entry_t       map_table [ARCH_REGS];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   count;
    logic             err_q;

    logic       list_empty;
    logic       list_full;
    logic       rd_nonzero;
    logic       do_pop;
    logic       do_push;
    logic       retire_overflow;
    logic       retire_clear;
    map_entry_t src1_entry;
    map_entry_t src2_entry;
    map_entry_t retire_entry;

    assign list_empty = (count == '0);
    assign list_full  = (count == FULL_COUNT);
    assign rd_nonzero = (ALLOC_RD != '0);

    // A retire arriving while the list is empty only refills it for next cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        ALLOC_GNT       = 1'b0;
        ALLOC_TAG_VALID = 1'b0;
        STALL           = 1'b0;
        do_pop          = 1'b0;
        if (ALLOC_REQ) begin
            if (!rd_nonzero) begin
                ALLOC_GNT = !FLUSH;
            end else if (list_empty) begin
                STALL = 1'b1;
            end else begin
                ALLOC_GNT       = !FLUSH;
                ALLOC_TAG_VALID = !FLUSH;
                do_pop          = !FLUSH;
            end
        end
    end

    assign ALLOC_TAG       = free_list[head];
    assign do_push         = RETIRE_EN && !list_full && !FLUSH;
    assign retire_overflow = RETIRE_EN && list_full && !FLUSH;

    assign retire_entry = map_table[RETIRE_RD];
    assign retire_clear = RETIRE_EN && retire_entry.valid && (retire_entry.tag == RETIRE_TAG);

    // Lookups use the pre-update table, so an instruction never sees its own rd.
    assign src1_entry   = map_table[SRC1_RS];
    assign src2_entry   = map_table[SRC2_RS];
    assign SRC1_RENAMED = (SRC1_RS != '0) && src1_entry.valid;
    assign SRC2_RENAMED = (SRC2_RS != '0) && src2_entry.valid;
    assign SRC1_TAG     = SRC1_RENAMED ? src1_entry.tag : '0;
    assign SRC2_TAG     = SRC2_RENAMED ? src2_entry.tag : '0;

    assign FREE_COUNT = count;
    assign ERR        = err_q;

    // NOTE: free list and map table are reset explicitly: their reset contents are architectural state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < RRF_DEPTH; i++) free_list[i] <= TAG_W'(i);
            for (int r = 0; r < ARCH_REGS; r++) map_table[r] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= FULL_COUNT;
        end else if (FLUSH) begin
            for (int i = 0; i < RRF_DEPTH; i++) free_list[i] <= TAG_W'(i);
            for (int r = 0; r < ARCH_REGS; r++) map_table[r] <= '0;
            head  <= '0;
            tail  <= '0;
            count <= FULL_COUNT;
        end else begin
            if (do_pop) head <= head + TAG_W'(1);
            if (do_push) begin
                free_list[tail] <= RETIRE_TAG;
                tail            <= tail + TAG_W'(1);
            end
            count <= count + {{TAG_W{1'b0}}, do_push} - {{TAG_W{1'b0}}, do_pop};
            // NOTE: non-blocking assignments; the later allocation write overrides the retire clear when rd matches.
            if (retire_clear) map_table[RETIRE_RD].valid <= 1'b0;
            if (do_pop) map_table[ALLOC_RD] <= '{valid: 1'b1, tag: free_list[head]};
        end
    end

    // Sticky overflow flag survives FLUSH; only RESET clears it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            err_q <= 1'b0;
        end else if (retire_overflow) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rename_alloc_unit.sv
// Self-checking bench for rename_alloc_unit: directed scenarios followed by
// randomized traffic compared against a queue-based reference model.
module tb_rename_alloc_unit;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       FLUSH;
    logic       ALLOC_REQ;
    logic [4:0] ALLOC_RD;
    logic [4:0] SRC1_RS;
    logic [4:0] SRC2_RS;
    logic       RETIRE_EN;
    logic [3:0] RETIRE_TAG;
    logic [4:0] RETIRE_RD;
    logic       ALLOC_GNT;
    logic [3:0] ALLOC_TAG;
    logic       ALLOC_TAG_VALID;
    logic       STALL;
    logic       SRC1_RENAMED;
    logic [3:0] SRC1_TAG;
    logic       SRC2_RENAMED;
    logic [3:0] SRC2_TAG;
    logic [4:0] FREE_COUNT;
    logic       ERR;

    rename_alloc_unit dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
        .ALLOC_REQ(ALLOC_REQ), .ALLOC_RD(ALLOC_RD),
        .SRC1_RS(SRC1_RS), .SRC2_RS(SRC2_RS),
        .ALLOC_GNT(ALLOC_GNT), .ALLOC_TAG(ALLOC_TAG),
        .ALLOC_TAG_VALID(ALLOC_TAG_VALID), .STALL(STALL),
        .SRC1_RENAMED(SRC1_RENAMED), .SRC1_TAG(SRC1_TAG),
        .SRC2_RENAMED(SRC2_RENAMED), .SRC2_TAG(SRC2_TAG),
        .RETIRE_EN(RETIRE_EN), .RETIRE_TAG(RETIRE_TAG), .RETIRE_RD(RETIRE_RD),
        .FREE_COUNT(FREE_COUNT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: free tags as a FIFO queue, map as plain arrays.
    typedef struct { int tag; int rd; } flight_t;
    int      free_q[$];
    bit      m_valid[32];
    int      m_tag[32];
    bit      m_err;
    flight_t inflight[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear_lists();
        free_q.delete();
        for (int i = 0; i < 16; i++) free_q.push_back(i);
        for (int r = 0; r < 32; r++) begin
            m_valid[r] = 1'b0;
            m_tag[r]   = 0;
        end
        inflight.delete();
    endtask

    task automatic model_reset();
        model_clear_lists();
        m_err = 1'b0;
    endtask

    task automatic compare_all();
        bit exp_pop;
        bit exp_r1;
        bit exp_r2;
        exp_pop = !FLUSH && ALLOC_REQ && ALLOC_RD != 0 && free_q.size() > 0;
        check("free_count", 32'(FREE_COUNT), 32'(free_q.size()));
        check("alloc_gnt", 32'(ALLOC_GNT), 32'(!FLUSH && ALLOC_REQ && (ALLOC_RD == 0 || free_q.size() > 0)));
        check("alloc_tag_valid", 32'(ALLOC_TAG_VALID), 32'(exp_pop));
        if (free_q.size() > 0) check("alloc_tag", 32'(ALLOC_TAG), 32'(free_q[0]));
        if (!FLUSH) check("stall", 32'(STALL), 32'(ALLOC_REQ && ALLOC_RD != 0 && free_q.size() == 0));
        exp_r1 = SRC1_RS != 0 && m_valid[SRC1_RS];
        exp_r2 = SRC2_RS != 0 && m_valid[SRC2_RS];
        check("src1_renamed", 32'(SRC1_RENAMED), 32'(exp_r1));
        check("src1_tag", 32'(SRC1_TAG), exp_r1 ? 32'(m_tag[SRC1_RS]) : 32'd0);
        check("src2_renamed", 32'(SRC2_RENAMED), 32'(exp_r2));
        check("src2_tag", 32'(SRC2_TAG), exp_r2 ? 32'(m_tag[SRC2_RS]) : 32'd0);
        check("err", 32'(ERR), 32'(m_err));
    endtask

    task automatic model_update();
        int  n;
        int  t;
        bit  pop;
        n   = free_q.size();
        pop = !FLUSH && ALLOC_REQ && ALLOC_RD != 0 && n > 0;
        t   = 0;
        if (FLUSH) begin
            model_clear_lists();
        end else begin
            if (pop) t = free_q.pop_front();
            if (RETIRE_EN) begin
                if (n == 16) m_err = 1'b1;
                else free_q.push_back(int'(RETIRE_TAG));
                if (m_valid[RETIRE_RD] && m_tag[RETIRE_RD] == int'(RETIRE_TAG)) m_valid[RETIRE_RD] = 1'b0;
                for (int k = 0; k < inflight.size(); k++) begin
                    if (inflight[k].tag == int'(RETIRE_TAG)) begin
                        inflight.delete(k);
                        break;
                    end
                end
            end
            if (pop) begin
                m_valid[ALLOC_RD] = 1'b1;
                m_tag[ALLOC_RD]   = t;
                inflight.push_back('{tag: t, rd: int'(ALLOC_RD)});
            end
        end
    endtask

    task automatic drive(input bit req, input int rd, input int rs1, input int rs2,
                         input bit ret, input int rtag, input int rrd, input bit fl);
        ALLOC_REQ  = req;
        ALLOC_RD   = 5'(rd);
        SRC1_RS    = 5'(rs1);
        SRC2_RS    = 5'(rs2);
        RETIRE_EN  = ret;
        RETIRE_TAG = 4'(rtag);
        RETIRE_RD  = 5'(rrd);
        FLUSH      = fl;
    endtask

    // Inputs change on the falling edge; outputs are compared 1 time unit later.
    task automatic cycle();
        #1;
        compare_all();
        @(posedge CLK);
        model_update();
        @(negedge CLK);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        RESET = 1'b1;
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge CLK);
        RESET = 1'b0;

        // Reset state
        #1;
        check("rst_alloc_tag", 32'(ALLOC_TAG), 0);
        check("rst_free_count", 32'(FREE_COUNT), 16);
        check("rst_gnt", 32'(ALLOC_GNT), 0);
        check("rst_stall", 32'(STALL), 0);
        check("rst_src1_renamed", 32'(SRC1_RENAMED), 0);
        check("rst_src2_tag", 32'(SRC2_TAG), 0);
        check("rst_err", 32'(ERR), 0);

        // Single allocation, visible next cycle
        drive(1, 5, 5, 0, 0, 0, 0, 0);
        #1;
        check("a5_gnt", 32'(ALLOC_GNT), 1);
        check("a5_tag", 32'(ALLOC_TAG), 0);
        check("a5_no_self_see", 32'(SRC1_RENAMED), 0);
        cycle();
        drive(0, 0, 5, 0, 0, 0, 0, 0);
        #1;
        check("a5_free", 32'(FREE_COUNT), 15);
        check("a5_src1_renamed", 32'(SRC1_RENAMED), 1);
        check("a5_src1_tag", 32'(SRC1_TAG), 0);
        cycle();

        // Drain the list, stall, retire-without-bypass, then regrant
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            drive(1, i + 1, 0, 0, 0, 0, 0, 0);
            #1;
            check("drain_tag", 32'(ALLOC_TAG), 32'(i));
            cycle();
        end
        drive(1, 17, 0, 0, 0, 0, 0, 0);
        #1;
        check("empty_stall", 32'(STALL), 1);
        check("empty_gnt", 32'(ALLOC_GNT), 0);
        check("empty_free", 32'(FREE_COUNT), 0);
        cycle();
        drive(1, 17, 0, 0, 1, 3, 4, 0);
        #1;
        check("no_bypass_stall", 32'(STALL), 1);
        check("no_bypass_gnt", 32'(ALLOC_GNT), 0);
        cycle();
        drive(1, 17, 4, 0, 0, 0, 0, 0);
        #1;
        check("regrant_gnt", 32'(ALLOC_GNT), 1);
        check("regrant_tag", 32'(ALLOC_TAG), 3);
        check("retired_rd4_clear", 32'(SRC1_RENAMED), 0);
        cycle();

        // Stale-tag retire keeps the newer mapping
        apply_reset();
        drive(1, 7, 0, 0, 0, 0, 0, 0); cycle();
        drive(1, 7, 0, 0, 0, 0, 0, 0); cycle();
        drive(0, 0, 0, 0, 1, 0, 7, 0); cycle();
        drive(0, 0, 7, 0, 0, 0, 0, 0);
        #1;
        check("stale_renamed", 32'(SRC1_RENAMED), 1);
        check("stale_tag", 32'(SRC1_TAG), 1);
        cycle();
        drive(0, 0, 0, 0, 1, 1, 7, 0); cycle();
        drive(0, 0, 7, 0, 0, 0, 0, 0);
        #1;
        check("cur_retire_clear", 32'(SRC1_RENAMED), 0);
        cycle();

        // Simultaneous alloc and retire on the same rd
        apply_reset();
        drive(1, 9, 0, 0, 0, 0, 0, 0); cycle();
        for (int i = 1; i < 8; i++) begin
            drive(1, i, 0, 0, 0, 0, 0, 0);
            cycle();
        end
        drive(1, 9, 0, 0, 1, 0, 9, 0); cycle();
        drive(0, 0, 9, 0, 0, 0, 0, 0);
        #1;
        check("same_free", 32'(FREE_COUNT), 8);
        check("same_renamed", 32'(SRC1_RENAMED), 1);
        check("same_tag", 32'(SRC1_TAG), 8);
        cycle();

        // rd=0 allocation
        apply_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("x0_gnt", 32'(ALLOC_GNT), 1);
        check("x0_tag_valid", 32'(ALLOC_TAG_VALID), 0);
        check("x0_src1", 32'(SRC1_RENAMED), 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("x0_free", 32'(FREE_COUNT), 16);
        cycle();

        // Flush, overflow retire, asynchronous reset
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            drive(1, i, 0, 0, 0, 0, 0, 0);
            cycle();
        end
        drive(1, 6, 0, 0, 0, 0, 0, 1);
        #1;
        check("flush_gnt", 32'(ALLOC_GNT), 0);
        cycle();
        drive(0, 0, 1, 5, 0, 0, 0, 0);
        #1;
        check("flush_free", 32'(FREE_COUNT), 16);
        check("flush_alloc_tag", 32'(ALLOC_TAG), 0);
        check("flush_src1", 32'(SRC1_RENAMED), 0);
        check("flush_src2", 32'(SRC2_RENAMED), 0);
        cycle();
        drive(0, 0, 0, 0, 1, 2, 3, 0); cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("ovf_err", 32'(ERR), 1);
        check("ovf_free", 32'(FREE_COUNT), 16);
        cycle();
        RESET = 1'b1;
        #1;
        check("async_rst_err", 32'(ERR), 0);
        model_reset();
        @(negedge CLK);
        RESET = 1'b0;

        // Randomized traffic against the model
        for (int it = 0; it < 2000; it++) begin
            bit req;
            bit ret;
            bit fl;
            int rd;
            int rtag;
            int rrd;
            int pct;
            pct  = (it < 1000) ? 30 : 65;
            req  = ($urandom_range(0, 9) < 7);
            rd   = $urandom_range(0, 9);
            ret  = 1'b0;
            rtag = $urandom_range(0, 15);
            rrd  = $urandom_range(0, 31);
            fl   = ($urandom_range(0, 127) == 0);
            if (inflight.size() > 0 && $urandom_range(0, 99) < pct) begin
                int k;
                k    = $urandom_range(0, inflight.size() - 1);
                ret  = 1'b1;
                rtag = inflight[k].tag;
                rrd  = inflight[k].rd;
            end
            drive(req, rd, $urandom_range(0, 9), $urandom_range(0, 9), ret, rtag, rrd, fl);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
